// File: rtl/fetch_unit.sv
// fetch_unit: PC register, next-PC select, stall/redirect capture and IF/ID latch.
// Ports: CLK/RST (sync, active-high), pcen/pcsrc/targets/flush/halt control,
//   ihit/iload from imem, imemREN/imemaddr request, ifid_* registered bundle.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        pcen,
    input  logic [2:0]  pcsrc,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] jr_target,
    input  logic        flush,
    input  logic        halt,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_npc,
    output logic        ifid_valid
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALTED
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redir;
    logic [31:0] tgt;
    logic        pend_valid;
    logic [31:0] pend_target;

    assign pc_plus4 = pc + 32'd4;
    assign imemaddr = pc;
    assign imemREN  = (state == FETCH);

    always_comb begin
        redir = 1'b0;
        tgt   = 32'h0;
        case (pcsrc)
            3'b001: begin
                redir = 1'b1;
                tgt   = branch_target;
            end
            3'b010: begin
                redir = 1'b1;
                tgt   = jump_target;
            end
            3'b011: begin
                redir = 1'b1;
                tgt   = jr_target;
            end
            default: begin
                redir = 1'b0;
                tgt   = 32'h0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            pc          <= PC_INIT;
            pend_valid  <= 1'b0;
            pend_target <= 32'h0;
            ifid_instr  <= 32'h0;
            ifid_npc    <= 32'h0;
            ifid_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state      <= FETCH;
                    ifid_valid <= 1'b0;
                end
                FETCH: begin
                    if (!pcen) begin
                        // Stalled: remember the newest redirect so it is
                        // not lost when the hazard clears.
                        if (redir) begin
                            pend_valid  <= 1'b1;
                            pend_target <= tgt;
                        end
                    end else if (halt) begin
                        state      <= HALTED;
                        ifid_valid <= 1'b0;
                    end else if (redir) begin
                        pc         <= tgt;
                        pend_valid <= 1'b0;
                        ifid_valid <= 1'b0;
                    end else if (pend_valid) begin
                        pc         <= pend_target;
                        pend_valid <= 1'b0;
                        ifid_valid <= 1'b0;
                    end else if (ihit) begin
                        pc         <= pc_plus4;
                        ifid_instr <= iload;
                        ifid_npc   <= pc_plus4;
                        ifid_valid <= 1'b1;
                    end else begin
                        ifid_valid <= 1'b0;
                    end
                end
                HALTED: begin
                    ifid_valid <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    ifid_valid <= 1'b0;
                end
            endcase
            // Flush squashes the latch regardless of stall or state.
            if (flush) ifid_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a queue-based scoreboard; the monitor
// compares every post-edge output snapshot against the hand-computed entry.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        pcen;
    logic [2:0]  pcsrc;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target;
    logic        flush;
    logic        halt;
    logic        ihit;
    logic [31:0] iload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_npc;
    logic        ifid_valid;

    fetch_unit #(.PC_INIT(32'h0)) dut (
        .CLK(CLK),
        .RST(RST),
        .pcen(pcen),
        .pcsrc(pcsrc),
        .branch_target(branch_target),
        .jump_target(jump_target),
        .jr_target(jr_target),
        .flush(flush),
        .halt(halt),
        .ihit(ihit),
        .iload(iload),
        .imemREN(imemREN),
        .imemaddr(imemaddr),
        .ifid_instr(ifid_instr),
        .ifid_npc(ifid_npc),
        .ifid_valid(ifid_valid)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic        ren;
        logic [31:0] addr;
        logic        v;
        logic        chk_data;
        logic [31:0] ins;
        logic [31:0] npc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Monitor: one snapshot per rising edge, sampled 1 time unit later.
    always @(posedge CLK) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            logic ok;
            e  = exp_q.pop_front();
            ok = (imemREN === e.ren) && (imemaddr === e.addr) &&
                 (ifid_valid === e.v);
            if (e.chk_data)
                ok = ok && (ifid_instr === e.ins) && (ifid_npc === e.npc);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL %s: got ren=%0b addr=%h v=%0b ins=%h npc=%h, want ren=%0b addr=%h v=%0b ins=%h npc=%h",
                         e.name, imemREN, imemaddr, ifid_valid, ifid_instr,
                         ifid_npc, e.ren, e.addr, e.v, e.ins, e.npc);
            end
        end
    end

    task automatic cyc(input string nm, input logic rst, input logic en,
                       input logic [2:0] src, input logic fl,
                       input logic hl, input logic ih,
                       input logic [31:0] ld, input logic e_ren,
                       input logic [31:0] e_addr, input logic e_v,
                       input logic e_chk, input logic [31:0] e_ins,
                       input logic [31:0] e_npc);
        exp_t e;
        @(negedge CLK);
        RST   = rst;
        pcen  = en;
        pcsrc = src;
        flush = fl;
        halt  = hl;
        ihit  = ih;
        iload = ld;
        e.name     = nm;
        e.ren      = e_ren;
        e.addr     = e_addr;
        e.v        = e_v;
        e.chk_data = e_chk;
        e.ins      = e_ins;
        e.npc      = e_npc;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1; pcen = 1'b0; pcsrc = 3'b000; flush = 1'b0;
        halt = 1'b0; ihit = 1'b0; iload = 32'h0;
        branch_target = 32'h100;
        jump_target   = 32'h300;
        jr_target     = 32'h200;

        //   name        rst en src   fl hl ih ld          ren addr          v  chk ins         npc
        cyc("reset",      1, 0, 3'd0, 0, 0, 0, 32'h0,      0, 32'h0,        0, 1, 32'h0,      32'h0);
        cyc("idle",       0, 1, 3'd0, 0, 0, 1, 32'hA,      1, 32'h0,        0, 1, 32'h0,      32'h0);
        cyc("fetch_a",    0, 1, 3'd0, 0, 0, 1, 32'hA,      1, 32'h4,        1, 1, 32'hA,      32'h4);
        cyc("fetch_b",    0, 1, 3'd0, 0, 0, 1, 32'hB,      1, 32'h8,        1, 1, 32'hB,      32'h8);
        cyc("fetch_c",    0, 1, 3'd0, 0, 0, 1, 32'hC,      1, 32'hC,        1, 1, 32'hC,      32'hC);
        cyc("fetch_d",    0, 1, 3'd0, 0, 0, 1, 32'hD,      1, 32'h10,       1, 1, 32'hD,      32'h10);
        cyc("miss_1",     0, 1, 3'd0, 0, 0, 0, 32'hEE,     1, 32'h10,       0, 1, 32'hD,      32'h10);
        cyc("miss_2",     0, 1, 3'd0, 0, 0, 0, 32'hEE,     1, 32'h10,       0, 1, 32'hD,      32'h10);
        cyc("resume",     0, 1, 3'd0, 0, 0, 1, 32'hE,      1, 32'h14,       1, 1, 32'hE,      32'h14);
        cyc("flush_run",  0, 1, 3'd0, 1, 0, 1, 32'h5E,     1, 32'h18,       0, 0, 32'h0,      32'h0);
        cyc("after_fl",   0, 1, 3'd0, 0, 0, 1, 32'hE2,     1, 32'h1C,       1, 1, 32'hE2,     32'h1C);
        cyc("stall_br1",  0, 0, 3'd1, 0, 0, 1, 32'hF,      1, 32'h1C,       1, 1, 32'hE2,     32'h1C);
        cyc("stall_br2",  0, 0, 3'd1, 0, 0, 1, 32'hF,      1, 32'h1C,       1, 1, 32'hE2,     32'h1C);
        cyc("stall_br3",  0, 0, 3'd1, 0, 0, 1, 32'hF,      1, 32'h1C,       1, 1, 32'hE2,     32'h1C);
        cyc("pend_take",  0, 1, 3'd0, 0, 0, 1, 32'hF,      1, 32'h100,      0, 1, 32'hE2,     32'h1C);
        cyc("pend_again", 0, 0, 3'd1, 0, 0, 1, 32'hF,      1, 32'h100,      0, 1, 32'hE2,     32'h1C);
        cyc("jr_wins",    0, 1, 3'd3, 0, 0, 1, 32'hF,      1, 32'h200,      0, 1, 32'hE2,     32'h1C);
        cyc("pend_clr",   0, 1, 3'd0, 0, 0, 1, 32'h11,     1, 32'h204,      1, 1, 32'h11,     32'h204);
        cyc("ovw_br",     0, 0, 3'd1, 0, 0, 1, 32'h12,     1, 32'h204,      1, 1, 32'h11,     32'h204);
        cyc("ovw_jmp",    0, 0, 3'd2, 0, 0, 1, 32'h12,     1, 32'h204,      1, 1, 32'h11,     32'h204);
        cyc("ovw_take",   0, 1, 3'd0, 0, 0, 1, 32'h12,     1, 32'h300,      0, 1, 32'h11,     32'h204);
        cyc("br_hit",     0, 1, 3'd1, 0, 0, 1, 32'h22,     1, 32'h100,      0, 1, 32'h11,     32'h204);
        cyc("src_101",    0, 1, 3'd5, 0, 0, 1, 32'h33,     1, 32'h104,      1, 1, 32'h33,     32'h104);
        jr_target = 32'hFFFF_FFFC;
        cyc("jr_top",     0, 1, 3'd3, 0, 0, 1, 32'h33,     1, 32'hFFFFFFFC, 0, 1, 32'h33,     32'h104);
        cyc("wrap",       0, 1, 3'd0, 0, 0, 1, 32'h44,     1, 32'h0,        1, 1, 32'h44,     32'h0);
        cyc("flush_stl",  0, 0, 3'd0, 1, 0, 1, 32'h45,     1, 32'h0,        0, 1, 32'h44,     32'h0);
        cyc("halt_stl",   0, 0, 3'd0, 0, 1, 1, 32'h46,     1, 32'h0,        0, 1, 32'h44,     32'h0);
        cyc("halt",       0, 1, 3'd0, 0, 1, 1, 32'h55,     0, 32'h0,        0, 1, 32'h44,     32'h0);
        cyc("halted_br",  0, 1, 3'd1, 0, 0, 1, 32'h56,     0, 32'h0,        0, 1, 32'h44,     32'h0);
        cyc("halted_hit", 0, 1, 3'd0, 0, 0, 1, 32'h57,     0, 32'h0,        0, 1, 32'h44,     32'h0);
        cyc("reset2",     1, 0, 3'd0, 0, 0, 0, 32'h0,      0, 32'h0,        0, 1, 32'h0,      32'h0);
        cyc("idle2",      0, 1, 3'd0, 0, 0, 1, 32'h77,     1, 32'h0,        0, 1, 32'h0,      32'h0);
        cyc("fetch_77",   0, 1, 3'd0, 0, 0, 1, 32'h77,     1, 32'h4,        1, 1, 32'h77,     32'h4);
        cyc("stall_pend", 0, 0, 3'd1, 0, 0, 1, 32'h78,     1, 32'h4,        1, 1, 32'h77,     32'h4);
        cyc("rst_stall",  1, 0, 3'd1, 0, 0, 1, 32'h79,     0, 32'h0,        0, 1, 32'h0,      32'h0);
        cyc("idle3",      0, 1, 3'd0, 0, 0, 1, 32'h66,     1, 32'h0,        0, 1, 32'h0,      32'h0);
        cyc("no_pend",    0, 1, 3'd0, 0, 0, 1, 32'h66,     1, 32'h4,        1, 1, 32'h66,     32'h4);

        @(posedge CLK);
        #3;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_INIT, default 32'h00000000, the PC value loaded on reset.
REQ-002 SHALL have port CLK  input  1  rising-edge clock for all state.
REQ-003 SHALL have port RST  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-004 SHALL have port pcen  input  1  hazard-unit enable; 0 freezes PC and IF/ID.
REQ-005 SHALL have port pcsrc  input  3  next-PC select: 000 PC+4, 001 branch, 010 jump, 011 jr; 100-111 treated as 000.
REQ-006 SHALL have ports branch_target, jump_target, jr_target  input  32 each  redirect addresses.
REQ-007 SHALL have port flush  input  1  squash IF/ID contents.
REQ-008 SHALL have port halt  input  1  halt decoded; stop fetching.
REQ-009 SHALL have ports ihit  input  1 and iload  input  32  instruction-memory hit and data.
REQ-010 SHALL have ports imemREN  output  1 and imemaddr  output  32  instruction read request.
REQ-011 SHALL have ports ifid_instr  output  32, ifid_npc  output  32 (PC+4 of fetched instr), ifid_valid  output  1.

Function
REQ-012 SHALL implement FSM states IDLE, FETCH, HALTED; IDLE -> FETCH after exactly one cycle; FETCH -> HALTED when halt=1 and pcen=1; HALTED left only by RST.
REQ-013 SHALL drive imemaddr = PC combinationally in all states; imemREN = 1 only in FETCH.
REQ-014 Redirect SHALL mean pcsrc in {001,010,011}; target = branch_target, jump_target or jr_target respectively.
REQ-015 In FETCH with pcen=1 and a redirect: PC <= target next edge; IF/ID valid <= 0 irrespective of ihit.
REQ-016 In FETCH with pcen=1, no redirect, no pending redirect, ihit=1: PC <= PC+4; ifid_instr <= iload, ifid_npc <= PC+4, ifid_valid <= 1.
REQ-017 In FETCH with pcen=1, no redirect, ihit=0: PC holds; ifid_valid <= 0 (bubble).
REQ-018 With pcen=0: PC, ifid_instr, ifid_npc hold; a redirect seen this cycle SHALL be captured in a pending register (pend_valid <= 1, pend_target <= target); a later redirect while still stalled overwrites it.
REQ-019 With pcen=1 and pend_valid=1 and no new redirect: PC <= pend_target, pend_valid <= 0, ifid_valid <= 0.
REQ-020 New redirect and pend_valid=1 with pcen=1 in the same cycle: new redirect wins; pending cleared.
REQ-021 flush=1 SHALL force ifid_valid <= 0 at the next edge regardless of pcen, ihit, or state; PC update unaffected by flush.
REQ-022 halt=1 with pcen=1: PC holds, ifid_valid <= 0, state -> HALTED; halt with pcen=0 is ignored until pcen=1.
REQ-023 In IDLE and HALTED: PC, pending register and ifid_instr/ifid_npc hold; ifid_valid <= 0.
REQ-024 PC+4 SHALL be modulo 2^32 (32'hFFFFFFFC + 4 = 32'h00000000); targets used unmodified (no alignment check).
REQ-025 Latency: an instruction with ihit=1 at edge N SHALL appear on ifid_* after edge N (one-cycle registered).

Reset
REQ-026 RST=1 at a rising edge SHALL set PC = PC_INIT, state = IDLE, pend_valid = 0, pend_target = 0, ifid_instr = 0, ifid_npc = 0, ifid_valid = 0, overriding all other inputs, including mid-stall or mid-redirect.
REQ-027 After RST release: first cycle imemREN=0 (IDLE), imemREN=1 from the second cycle.

Verification
REQ-028 Reset then pcen=1, ihit=1 for 3 cycles with iload=0xA,0xB,0xC -> imemaddr 0,4,8,12; ifid_instr 0xA/0xB/0xC, ifid_npc 4/8/12, ifid_valid=1.
REQ-029 ihit=0 for 2 cycles at PC=0x10 -> PC stays 0x10, ifid_valid=0 both cycles, resumes with ifid_npc=0x14 when ihit=1.
REQ-030 pcen=0, pcsrc=001, branch_target=0x100 for 3 cycles -> PC held; pcen=1 with pcsrc=000 -> PC=0x100, ifid_valid=0 that cycle.
REQ-031 Pending target 0x100 plus pcen=1 with pcsrc=011, jr_target=0x200 -> PC=0x200, pend_valid=0.
REQ-032 PC=0xFFFFFFFC, ihit=1 -> PC=0x0, ifid_npc=0x0; then halt=1, pcen=1 -> imemREN=0 next cycle, ifid_valid=0, stays halted until RST.
REQ-033 flush=1 with pcen=0 and ifid_valid=1 -> ifid_valid=0 next cycle, ifid_instr unchanged; RST asserted mid-stall -> all REQ-026 values.
